// File: rtl/bit_serial_alu_seq.sv
// Bit-serial sequencer for one external 1-bit ALU slice: one request and one response.
// Optional flag: define BIT_SERIAL_ALU_OVF_EN to add the resp_ovf output.
//
// Ports:
//   clk, rst_n            clock and async active-low reset
//   req_valid/req_ready   request handshake
//   req_a, req_b          WIDTH-bit operands
//   req_aop               3-bit opcode
//   slice_a/b/cin/aop     drive into the external slice (0 outside SHIFT)
//   slice_out/slice_cout  slice result bit and carry
//   resp_valid/ready      response handshake
//   resp_result           assembled result
//   resp_carry            final carry, ADD/SUB only
//   resp_zero             result is zero
//   resp_err              illegal opcode
//   resp_ovf              signed overflow (only with BIT_SERIAL_ALU_OVF_EN)
module bit_serial_alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_aop,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [2:0]       slice_aop,
  input  logic             slice_out,
  input  logic             slice_cout,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_carry,
  output logic             resp_zero,
`ifdef BIT_SERIAL_ALU_OVF_EN
  output logic             resp_ovf,
`endif
  output logic             resp_err
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [2:0] OP_SUB = 3'b110;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [2:0]       aop_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;

  logic             in_shift;
  logic             is_arith;
  logic             last;
  logic             req_bad;
  logic [WIDTH-1:0] res_nxt;

  assign in_shift = (state == SHIFT);
  // ADD (010) and SUB (110) share the low opcode bits.
  assign is_arith = (aop_q[1:0] == 2'b10);
  assign req_bad  = (req_aop[1:0] == 2'b11);
  assign last     = (cnt == CNT_W'(WIDTH - 1));
  // LSB arrives first, so each new bit enters at the MSB.
  assign res_nxt  = {slice_out, res[WIDTH-1:1]};

  assign slice_a     = in_shift & a_sh[0];
  assign slice_b     = in_shift & b_sh[0];
  // carry_q is preset to 1 for SUB, so bit 0 sees the +1 of two's complement.
  assign slice_cin   = in_shift & carry_q;
  assign slice_aop   = in_shift ? aop_q : 3'b000;
  assign resp_result = res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      aop_q      <= '0;
      carry_q    <= 1'b0;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_carry <= 1'b0;
      resp_zero  <= 1'b0;
      resp_err   <= 1'b0;
`ifdef BIT_SERIAL_ALU_OVF_EN
      resp_ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            a_sh       <= req_a;
            b_sh       <= req_b;
            aop_q      <= req_aop;
            res        <= '0;
            cnt        <= '0;
            carry_q    <= (req_aop == OP_SUB);
            req_ready  <= 1'b0;
            resp_carry <= 1'b0;
            resp_err   <= req_bad;
            resp_zero  <= req_bad;
`ifdef BIT_SERIAL_ALU_OVF_EN
            resp_ovf   <= 1'b0;
`endif
            if (req_bad) begin
              state      <= DONE;
              resp_valid <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          res     <= res_nxt;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          carry_q <= slice_cout;
          cnt     <= cnt + CNT_W'(1);
          if (last) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_carry <= is_arith & slice_cout;
            resp_zero  <= (res_nxt == '0);
`ifdef BIT_SERIAL_ALU_OVF_EN
            // carry_q still holds the carry into the MSB here.
            resp_ovf   <= is_arith & (carry_q ^ slice_cout);
`endif
          end
        end
        DONE: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Bench for bit_serial_alu_seq with a behavioural 1-bit ALU slice.
// Vector table plus directed back-pressure and mid-op reset sequences.
module tb_bit_serial_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic [2:0]   req_aop = '0;
  logic         slice_a;
  logic         slice_b;
  logic         slice_cin;
  logic [2:0]   slice_aop;
  logic         slice_out;
  logic         slice_cout;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [W-1:0] resp_result;
  logic         resp_carry;
  logic         resp_zero;
  logic         resp_err;
`ifdef BIT_SERIAL_ALU_OVF_EN
  logic         resp_ovf;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bit_serial_alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_aop    (req_aop),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_aop  (slice_aop),
    .slice_out  (slice_out),
    .slice_cout (slice_cout),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_result(resp_result),
    .resp_carry (resp_carry),
    .resp_zero  (resp_zero),
`ifdef BIT_SERIAL_ALU_OVF_EN
    .resp_ovf   (resp_ovf),
`endif
    .resp_err   (resp_err)
  );

  // Behavioural slice; cout for logic ops is deliberately nonzero
  // so the sequencer must mask it.
  logic bn;
  always_comb begin
    slice_out  = 1'b0;
    slice_cout = 1'b0;
    bn         = ~slice_b;
    case (slice_aop)
      3'b000: slice_out = slice_a;
      3'b001: begin
        slice_out  = ~slice_a;
        slice_cout = slice_a & slice_b;
      end
      3'b010: begin
        slice_out  = slice_a ^ slice_b ^ slice_cin;
        slice_cout = (slice_a & slice_b) | (slice_cin & (slice_a ^ slice_b));
      end
      3'b110: begin
        slice_out  = slice_a ^ bn ^ slice_cin;
        slice_cout = (slice_a & bn) | (slice_cin & (slice_a ^ bn));
      end
      3'b100: begin
        slice_out  = ~(slice_a | slice_b);
        slice_cout = slice_a & slice_b;
      end
      3'b101: begin
        slice_out  = ~(slice_a & slice_b);
        slice_cout = slice_a & slice_b;
      end
      default: begin
        slice_out  = 1'b0;
        slice_cout = 1'b0;
      end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]   aop;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         carry;
    logic         zero;
    logic         err;
    logic         ovf;
    int           lat;
  } vec_t;

  vec_t vecs[12];

  // Runs one op with resp_ready high; starts and ends #1 after a posedge.
  task automatic run_op(input logic [2:0] aop, input logic [W-1:0] a,
                        input logic [W-1:0] b, output logic [W-1:0] res,
                        output logic carry, output logic zero,
                        output logic err, output logic ovf,
                        output int lat, output logic cin0,
                        output logic act);
    int cyc;
    res  = '0;
    carry = 1'b0;
    zero = 1'b0;
    err  = 1'b0;
    ovf  = 1'b0;
    lat  = -1;
    cin0 = 1'b0;
    act  = 1'b0;
    req_a      = a;
    req_b      = b;
    req_aop    = aop;
    req_valid  = 1'b1;
    resp_ready = 1'b1;
    cyc = 0;
    while (cyc < 40 && lat < 0) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        req_valid = 1'b0;
        cin0 = slice_cin;
      end
      if (slice_aop != 3'b000) act = 1'b1;
      if (resp_valid) begin
        lat   = cyc;
        res   = resp_result;
        carry = resp_carry;
        zero  = resp_zero;
        err   = resp_err;
`ifdef BIT_SERIAL_ALU_OVF_EN
        ovf   = resp_ovf;
`endif
      end
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] r;
    logic c, z, e, o, ci, ac;
    int lat;
    int cyc;

    vecs[0]  = '{3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 9};
    vecs[1]  = '{3'b110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 9};
    vecs[2]  = '{3'b110, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 9};
    vecs[3]  = '{3'b101, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 9};
    vecs[4]  = '{3'b001, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 9};
    vecs[5]  = '{3'b000, 8'hA5, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 9};
    vecs[6]  = '{3'b100, 8'h0F, 8'h30, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 9};
    vecs[7]  = '{3'b010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 9};
    vecs[8]  = '{3'b110, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 9};
    vecs[9]  = '{3'b010, 8'h40, 8'h40, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 9};
    vecs[10] = '{3'b011, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    vecs[11] = '{3'b111, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1};

    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_result", 32'(resp_result), 32'd0);
    chk("rst_slice_aop", 32'(slice_aop), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].aop, vecs[i].a, vecs[i].b, r, c, z, e, o, lat, ci, ac);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_res", i), 32'(r), 32'(vecs[i].res));
      chk($sformatf("v%0d_carry", i), 32'(c), 32'(vecs[i].carry));
      chk($sformatf("v%0d_zero", i), 32'(z), 32'(vecs[i].zero));
      chk($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].err));
`ifdef BIT_SERIAL_ALU_OVF_EN
      chk($sformatf("v%0d_ovf", i), 32'(o), 32'(vecs[i].ovf));
`endif
      if (vecs[i].err)
        chk($sformatf("v%0d_slice_act", i), 32'(ac), 32'd0);
      else
        chk($sformatf("v%0d_cin0", i), 32'(ci),
            32'(vecs[i].aop == 3'b110));
    end

    // Back-pressure: response held 5 cycles with a second request waiting.
    req_a      = 8'h12;
    req_b      = 8'h34;
    req_aop    = 3'b010;
    req_valid  = 1'b1;
    resp_ready = 1'b0;
    cyc = 0;
    while (cyc < 40 && !resp_valid) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        req_a   = 8'h5A;
        req_b   = 8'h00;
        req_aop = 3'b000;
      end
    end
    chk("bp_lat", 32'(cyc), 32'd9);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold%0d_valid", k), 32'(resp_valid), 32'd1);
      chk($sformatf("bp_hold%0d_rdy", k), 32'(req_ready), 32'd0);
      chk($sformatf("bp_hold%0d_res", k), 32'(resp_result), 32'h46);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_drop_valid", 32'(resp_valid), 32'd0);
    chk("bp_idle_rdy", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("bp_second_acc", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    cyc = 1;
    while (cyc < 40 && !resp_valid) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("bp_second_lat", 32'(cyc), 32'd9);
    chk("bp_second_res", 32'(resp_result), 32'hA5 ^ 32'hFF);
    @(posedge clk);
    #1;
    resp_ready = 1'b0;

    // Reset pulse while bit 3 of an ADD is on the slice.
    req_a     = 8'h0F;
    req_b     = 8'h01;
    req_aop   = 3'b010;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("mid_in_shift", 32'(slice_aop), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    chk("arst_resp_valid", 32'(resp_valid), 32'd0);
    chk("arst_slice_aop", 32'(slice_aop), 32'd0);
    chk("arst_slice_a", 32'(slice_a), 32'd0);
    chk("arst_result", 32'(resp_result), 32'd0);
    @(posedge clk);
    #1;
    chk("arst_no_resp", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(3'b010, 8'h0F, 8'h01, r, c, z, e, o, lat, ci, ac);
    chk("post_rst_lat", 32'(lat), 32'd9);
    chk("post_rst_res", 32'(r), 32'h10);
    chk("post_rst_carry", 32'(c), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
